mandelbrot_alu_arbiter: RTL and testbench

- Shares one mandelbrot_alu iteration engine between NUM_REQ independent pixel engines (multi-core Mandelbrot, one shared multiplier datapath).
- Round-robin grant, operand latching, one ALU start pulse per operation, result routed back to the granted requester.
- Sits between the per-core iteration state machines and the single ALU instance; it does no arithmetic.

---
 rtl/mandelbrot_alu_arbiter_if.sv | 73 +++++++
 rtl/mandelbrot_alu_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mandelbrot_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// mandelbrot_alu_arbiter_if
//
// Purpose:
//   Bundles every handshake and bus signal between the ALU arbiter, the
//   per-core pixel engines and the shared mandelbrot_alu iteration engine.
//   The clock and reset stay plain module ports and are not part of this bundle.
//
// Modports:
//   master - arbiter view. It drives req_ready, rsp_*, alu_start, alu_* and
//            busy. It samples req_valid, req_* operands, alu_finished,
//            alu_zr_in, alu_zi_in, alu_size and alu_overflow.
//   slave  - environment view (requesters plus ALU), the mirror image.
//
// Signals (NUM_REQ requesters, WIDTH-bit operands):
//   req_valid/req_ready      per-requester request / accept (ready one-hot)
//   req_cr/ci/zr/zi          flattened operands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid                one-cycle per-requester result strobe
//   rsp_zr/zi/size/overflow  shared result bus qualified by rsp_valid
//   rsp_timeout              watchdog flag (0 unless the watchdog is built in)
//   alu_start, alu_cr/ci/zr/zi   start pulse and latched operands to the ALU
//   alu_finished, alu_zr_in/zi_in, alu_size/overflow   ALU done pulse and results
//   busy                     arbiter is not idle
// ----------------------------------------------------------------------------
interface mandelbrot_alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 10
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_cr;
    logic [NUM_REQ*WIDTH-1:0] req_ci;
    logic [NUM_REQ*WIDTH-1:0] req_zr;
    logic [NUM_REQ*WIDTH-1:0] req_zi;

    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_zr;
    logic [WIDTH-1:0]         rsp_zi;
    logic                     rsp_size;
    logic                     rsp_overflow;
    logic                     rsp_timeout;

    logic                     alu_start;
    logic [WIDTH-1:0]         alu_cr;
    logic [WIDTH-1:0]         alu_ci;
    logic [WIDTH-1:0]         alu_zr;
    logic [WIDTH-1:0]         alu_zi;
    logic                     alu_finished;
    logic [WIDTH-1:0]         alu_zr_in;
    logic [WIDTH-1:0]         alu_zi_in;
    logic                     alu_size;
    logic                     alu_overflow;

    logic                     busy;

    modport master (
        input  req_valid, req_cr, req_ci, req_zr, req_zi,
        output req_ready,
        output rsp_valid, rsp_zr, rsp_zi, rsp_size, rsp_overflow, rsp_timeout,
        output alu_start, alu_cr, alu_ci, alu_zr, alu_zi,
        input  alu_finished, alu_zr_in, alu_zi_in, alu_size, alu_overflow,
        output busy
    );

    modport slave (
        output req_valid, req_cr, req_ci, req_zr, req_zi,
        input  req_ready,
        input  rsp_valid, rsp_zr, rsp_zi, rsp_size, rsp_overflow, rsp_timeout,
        input  alu_start, alu_cr, alu_ci, alu_zr, alu_zi,
        output alu_finished, alu_zr_in, alu_zi_in, alu_size, alu_overflow,
        input  busy
    );
endinterface

// File: rtl/mandelbrot_alu_arbiter.sv
// ----------------------------------------------------------------------------
// mandelbrot_alu_arbiter
//
// Purpose:
//   Shares one mandelbrot_alu iteration engine between NUM_REQ pixel engines.
//   It grants requesters in round-robin order and latches the winner's
//   operands. It fires one ALU start pulse per operation and routes the
//   result back to the granted requester as a one-cycle strobe. It does no
//   arithmetic.
//
//   Sequence: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE
//   (one operation every L+3 cycles for ALU latency L).
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; the whole block returns to IDLE and
//          any in-flight operation is dropped without a response
//   bus    mandelbrot_alu_arbiter_if.master (requester + ALU signals)
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    operand / result width
//   TIMEOUT  watchdog limit in WAIT cycles (watchdog build only)
//
// Build option:
//   MANDEL_ARB_WATCHDOG_EN
//     When defined, an operation that stays in WAIT for TIMEOUT cycles
//     without alu_finished is answered with zero results and
//     rsp_overflow = rsp_timeout = 1.
//     When undefined, WAIT waits indefinitely and rsp_timeout is tied 0.
// ----------------------------------------------------------------------------
module mandelbrot_alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    mandelbrot_alu_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   lastGrant_q;
    logic [IDX_W-1:0]   grant_q;
    logic               aluStart_q;
    logic [WIDTH-1:0]   aluCr_q;
    logic [WIDTH-1:0]   aluCi_q;
    logic [WIDTH-1:0]   aluZr_q;
    logic [WIDTH-1:0]   aluZi_q;
    logic [NUM_REQ-1:0] rspValid_q;
    logic [WIDTH-1:0]   rspZr_q;
    logic [WIDTH-1:0]   rspZi_q;
    logic               rspSize_q;
    logic               rspOverflow_q;

`ifdef MANDEL_ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WD_W-1:0]    wdCount_q;
    logic               rspTimeout_q;
`else
    // TIMEOUT only matters in the watchdog build; this keeps it referenced.
    logic               unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
`endif

    // Round-robin search. Start one past the last grant and wrap modulo
    // NUM_REQ, so the most recently served requester is checked last.
    logic               grantFound;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W:0]     candidate;

    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candidate  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            candidate = {1'b0, lastGrant_q} + (IDX_W+1)'(i);
            if (candidate >= (IDX_W+1)'(NUM_REQ)) begin
                candidate = candidate - (IDX_W+1)'(NUM_REQ);
            end
            if (!grantFound && bus.req_valid[candidate[IDX_W-1:0]]) begin
                grantFound = 1'b1;
                grantIdx   = candidate[IDX_W-1:0];
            end
        end
    end

    // Operation sequencer. All outputs except req_ready and busy are registered.
    // Operands are captured only in the IDLE handshake cycle. Results are
    // captured only when alu_finished arrives in WAIT, so a stray finished
    // pulse in any other state is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lastGrant_q   <= IDX_W'(NUM_REQ - 1);
            grant_q       <= '0;
            aluStart_q    <= 1'b0;
            aluCr_q       <= '0;
            aluCi_q       <= '0;
            aluZr_q       <= '0;
            aluZi_q       <= '0;
            rspValid_q    <= '0;
            rspZr_q       <= '0;
            rspZi_q       <= '0;
            rspSize_q     <= 1'b0;
            rspOverflow_q <= 1'b0;
`ifdef MANDEL_ARB_WATCHDOG_EN
            wdCount_q     <= '0;
            rspTimeout_q  <= 1'b0;
`endif
        end else begin
            aluStart_q <= 1'b0;
            rspValid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grantFound) begin
                        aluCr_q     <= bus.req_cr[grantIdx*WIDTH +: WIDTH];
                        aluCi_q     <= bus.req_ci[grantIdx*WIDTH +: WIDTH];
                        aluZr_q     <= bus.req_zr[grantIdx*WIDTH +: WIDTH];
                        aluZi_q     <= bus.req_zi[grantIdx*WIDTH +: WIDTH];
                        grant_q     <= grantIdx;
                        lastGrant_q <= grantIdx;
                        aluStart_q  <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MANDEL_ARB_WATCHDOG_EN
                    wdCount_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.alu_finished) begin
                        rspZr_q       <= bus.alu_zr_in;
                        rspZi_q       <= bus.alu_zi_in;
                        rspSize_q     <= bus.alu_size;
                        rspOverflow_q <= bus.alu_overflow;
                        rspValid_q    <= ONE_HOT0 << grant_q;
                        state_q       <= RESPOND;
`ifdef MANDEL_ARB_WATCHDOG_EN
                        rspTimeout_q  <= 1'b0;
                    end else if (wdCount_q == WD_W'(TIMEOUT - 1)) begin
                        // TIMEOUT WAIT cycles passed without a result, so
                        // answer with an overflowed pixel.
                        rspZr_q       <= '0;
                        rspZi_q       <= '0;
                        rspSize_q     <= 1'b0;
                        rspOverflow_q <= 1'b1;
                        rspTimeout_q  <= 1'b1;
                        rspValid_q    <= ONE_HOT0 << grant_q;
                        state_q       <= RESPOND;
                    end else begin
                        wdCount_q     <= wdCount_q + 1'b1;
`endif
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The accept is combinational so the requester sees it in the same
    // cycle as the grant decision.
    assign bus.req_ready    = (state_q == IDLE && grantFound) ? (ONE_HOT0 << grantIdx) : '0;
    assign bus.busy         = (state_q != IDLE);

    assign bus.alu_start    = aluStart_q;
    assign bus.alu_cr       = aluCr_q;
    assign bus.alu_ci       = aluCi_q;
    assign bus.alu_zr       = aluZr_q;
    assign bus.alu_zi       = aluZi_q;

    assign bus.rsp_valid    = rspValid_q;
    assign bus.rsp_zr       = rspZr_q;
    assign bus.rsp_zi       = rspZi_q;
    assign bus.rsp_size     = rspSize_q;
    assign bus.rsp_overflow = rspOverflow_q;
`ifdef MANDEL_ARB_WATCHDOG_EN
    assign bus.rsp_timeout  = rspTimeout_q;
`else
    assign bus.rsp_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mandelbrot_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mandelbrot_alu_arbiter
//
// Purpose:
//   Self-checking bench for mandelbrot_alu_arbiter. It has two instances:
//   a 2-requester arbiter for the main sequences and a 4-requester arbiter
//   for wrap-around. Each instance has an ALU stub with a start-to-finished
//   latency of 2 cycles. The stub returns whatever result values the
//   current step loads into stubZr/stubZi/stubSize/stubOvf.
//
// Watchdog scenario runs only when MANDEL_ARB_WATCHDOG_EN is defined.
// ----------------------------------------------------------------------------
module tb_mandelbrot_alu_arbiter;

    localparam int W = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mandelbrot_alu_arbiter_if #(.NUM_REQ(2), .WIDTH(W)) bus2 ();
    mandelbrot_alu_arbiter_if #(.NUM_REQ(4), .WIDTH(W)) bus4 ();

    mandelbrot_alu_arbiter #(.NUM_REQ(2), .WIDTH(W), .TIMEOUT(63)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mandelbrot_alu_arbiter #(.NUM_REQ(4), .WIDTH(W), .TIMEOUT(63)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Shared stub result values and a hang switch for the watchdog case.
    logic [W-1:0] stubZr   = '0;
    logic [W-1:0] stubZi   = '0;
    logic         stubSize = 1'b0;
    logic         stubOvf  = 1'b0;
    logic         stubHang = 1'b0;
    logic         forceFin2 = 1'b0;

    logic pend2 = 1'b0;
    logic fin2  = 1'b0;
    logic pend4 = 1'b0;
    logic fin4  = 1'b0;

    // ALU stubs: start seen in cycle s raises finished in cycle s+2.
    always @(posedge clk) begin
        fin2 <= 1'b0;
        if (bus2.alu_start) begin
            pend2 <= 1'b1;
        end else if (pend2) begin
            pend2 <= 1'b0;
            fin2  <= !stubHang;
        end
    end

    always @(posedge clk) begin
        fin4 <= 1'b0;
        if (bus4.alu_start) begin
            pend4 <= 1'b1;
        end else if (pend4) begin
            pend4 <= 1'b0;
            fin4  <= !stubHang;
        end
    end

    assign bus2.alu_finished = fin2 | forceFin2;
    assign bus2.alu_zr_in    = stubZr;
    assign bus2.alu_zi_in    = stubZi;
    assign bus2.alu_size     = stubSize;
    assign bus2.alu_overflow = stubOvf;

    assign bus4.alu_finished = fin4;
    assign bus4.alu_zr_in    = stubZr;
    assign bus4.alu_zi_in    = stubZi;
    assign bus4.alu_size     = stubSize;
    assign bus4.alu_overflow = stubOvf;

    // Requester operands: req0 cr=5 ci=3 zr=0 zi=0, req1 cr=9 ci=4 zr=17 zi=21.
    localparam logic [2*W-1:0] REQ_CR2 = {10'd9,  10'd5};
    localparam logic [2*W-1:0] REQ_CI2 = {10'd4,  10'd3};
    localparam logic [2*W-1:0] REQ_ZR2 = {10'd17, 10'd0};
    localparam logic [2*W-1:0] REQ_ZI2 = {10'd21, 10'd0};

    typedef struct {
        logic [1:0]   valid;
        logic [W-1:0] stubZr;
        logic [W-1:0] stubZi;
        logic         stubSize;
        logic         stubOvf;
        logic [1:0]   expReady;
        logic [4*W-1:0] expOps;
        logic [1:0]   expRsp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 2-requester arbiter, starting at the
    // handshake cycle c0. Response is expected in c4; returns at c5.
    task automatic applyStimulus(input vec_t v, input string name);
        bus2.req_valid = v.valid;
        stubZr   = v.stubZr;
        stubZi   = v.stubZi;
        stubSize = v.stubSize;
        stubOvf  = v.stubOvf;
        #3;
        checkOutput({name, " ready"}, bus2.req_ready, v.expReady);
        checkOutput({name, " rsp quiet c0"}, bus2.rsp_valid, 2'b00);
        nextCycle();
        #3;
        checkOutput({name, " start/ready c1"}, {bus2.alu_start, bus2.req_ready}, {1'b1, 2'b00});
        checkOutput({name, " operands"},
                    {bus2.alu_cr, bus2.alu_ci, bus2.alu_zr, bus2.alu_zi}, v.expOps);
        nextCycle();
        bus2.req_cr = ~REQ_CR2;
        #3;
        checkOutput({name, " start/rsp/busy c2"},
                    {bus2.alu_start, bus2.rsp_valid, bus2.busy}, {1'b0, 2'b00, 1'b1});
        nextCycle();
        #3;
        checkOutput({name, " alu_cr stable"}, bus2.alu_cr, v.expOps[4*W-1 -: W]);
        checkOutput({name, " rsp quiet c3"}, bus2.rsp_valid, 2'b00);
        nextCycle();
        bus2.req_cr = REQ_CR2;
        #3;
        checkOutput({name, " rsp_valid"}, bus2.rsp_valid, v.expRsp);
        checkOutput({name, " rsp data"},
                    {bus2.rsp_zr, bus2.rsp_zi, bus2.rsp_size, bus2.rsp_overflow, bus2.rsp_timeout},
                    {v.stubZr, v.stubZi, v.stubSize, v.stubOvf, 1'b0});
        nextCycle();
    endtask

    // One operation on the 4-requester arbiter: checks grant, the issued
    // cr operand and the response routing.
    task automatic op4(input logic [3:0] v, input logic [3:0] expReady,
                       input logic [W-1:0] expCr, input string name);
        bus4.req_valid = v;
        #3;
        checkOutput({name, " ready"}, bus4.req_ready, expReady);
        nextCycle();
        bus4.req_valid = 4'b0000;
        #3;
        checkOutput({name, " start/cr"}, {bus4.alu_start, bus4.alu_cr}, {1'b1, expCr});
        nextCycle();
        nextCycle();
        nextCycle();
        #3;
        checkOutput({name, " rsp_valid"}, bus4.rsp_valid, expReady);
        nextCycle();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b01, 10'd100,  10'd200, 1'b0, 1'b0, 2'b01, {10'd5, 10'd3, 10'd0,  10'd0},  2'b01};
        vecs[1] = '{2'b11, 10'd300,  10'd400, 1'b0, 1'b1, 2'b10, {10'd9, 10'd4, 10'd17, 10'd21}, 2'b10};
        vecs[2] = '{2'b11, 10'h3F9,  10'd11,  1'b1, 1'b0, 2'b01, {10'd5, 10'd3, 10'd0,  10'd0},  2'b01};
        vecs[3] = '{2'b11, 10'd12,   10'd13,  1'b1, 1'b1, 2'b10, {10'd9, 10'd4, 10'd17, 10'd21}, 2'b10};
        vecs[4] = '{2'b10, 10'd1,    10'd2,   1'b0, 1'b0, 2'b10, {10'd9, 10'd4, 10'd17, 10'd21}, 2'b10};
        vecs[5] = '{2'b11, 10'h3FF,  10'd0,   1'b0, 1'b1, 2'b01, {10'd5, 10'd3, 10'd0,  10'd0},  2'b01};

        reset = 1'b1;
        bus2.req_valid = '0;
        bus2.req_cr = REQ_CR2;
        bus2.req_ci = REQ_CI2;
        bus2.req_zr = REQ_ZR2;
        bus2.req_zi = REQ_ZI2;
        bus4.req_valid = '0;
        bus4.req_cr = {10'd40, 10'd30, 10'd20, 10'd10};
        bus4.req_ci = {10'd4, 10'd3, 10'd2, 10'd1};
        bus4.req_zr = '0;
        bus4.req_zi = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #3;

        // Reset state of both arbiters.
        checkOutput("reset busy/start/rsp2",
                    {bus2.busy, bus2.alu_start, bus2.rsp_valid, bus2.req_ready}, 6'd0);
        checkOutput("reset alu ops2",
                    {bus2.alu_cr, bus2.alu_ci, bus2.alu_zr, bus2.alu_zi}, 40'd0);
        checkOutput("reset rsp data2",
                    {bus2.rsp_zr, bus2.rsp_zi, bus2.rsp_size, bus2.rsp_overflow, bus2.rsp_timeout}, 23'd0);
        checkOutput("reset busy/rsp4", {bus4.busy, bus4.rsp_valid, bus4.req_ready}, 9'd0);
        nextCycle();

        // Main table: first grant, round-robin 0,1,0,1, flags, re-request.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end
        bus2.req_valid = 2'b00;
        #3;

        // A stray alu_finished while idle must not produce a response.
        forceFin2 = 1'b1;
        nextCycle();
        forceFin2 = 1'b0;
        #3;
        checkOutput("stray finished busy/rsp", {bus2.busy, bus2.rsp_valid}, 3'b000);
        nextCycle();

        // Reset during WAIT: last grant is 0 beforehand, so a post-reset
        // request pair must go to requester 0 only if last_grant was reset.
        bus2.req_valid = 2'b01;
        #3;
        checkOutput("midreset grant", bus2.req_ready, 2'b01);
        nextCycle();
        bus2.req_valid = 2'b00;
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        bus2.req_valid = 2'b11;
        #3;
        checkOutput("midreset busy/rsp", {bus2.busy, bus2.rsp_valid}, 3'b000);
        checkOutput("midreset alu_cr cleared", bus2.alu_cr, 10'd0);
        checkOutput("midreset first grant", bus2.req_ready, 2'b01);
        stubZr = 10'd77;
        nextCycle();
        bus2.req_valid = 2'b00;
        #3;
        checkOutput("midreset start/cr", {bus2.alu_start, bus2.alu_cr, bus2.rsp_valid},
                    {1'b1, 10'd5, 2'b00});
        nextCycle();
        #3;
        checkOutput("midreset no rsp c5", bus2.rsp_valid, 2'b00);
        nextCycle();
        #3;
        checkOutput("midreset no rsp c6", bus2.rsp_valid, 2'b00);
        nextCycle();
        #3;
        checkOutput("midreset new rsp", {bus2.rsp_valid, bus2.rsp_zr}, {2'b01, 10'd77});
        nextCycle();

        // Wrap-around on the 4-requester arbiter (last grant 3 after reset).
        op4(4'b0101, 4'b0001, 10'd10, "wrap g0");
        op4(4'b0101, 4'b0100, 10'd30, "wrap g2");
        op4(4'b0101, 4'b0001, 10'd10, "wrap g0 again");
        op4(4'b1100, 4'b0100, 10'd30, "wrap g2 skip1");
        op4(4'b1001, 4'b1000, 10'd40, "wrap g3");
        op4(4'b1001, 4'b0001, 10'd10, "wrap g0 from3");

`ifdef MANDEL_ARB_WATCHDOG_EN
        begin
            int early;
            vec_t after;
            early = 0;
            stubHang = 1'b1;
            bus2.req_valid = 2'b01;
            nextCycle();
            bus2.req_valid = 2'b00;
            #3;
            checkOutput("wd start", bus2.alu_start, 1'b1);
            // WAIT occupies 63 cycles after the start cycle; response follows.
            for (int k = 2; k <= 64; k++) begin
                nextCycle();
                #3;
                if (bus2.rsp_valid !== 2'b00) early++;
            end
            checkOutput("wd early rsp count", early, 0);
            nextCycle();
            #3;
            checkOutput("wd rsp_valid", bus2.rsp_valid, 2'b01);
            checkOutput("wd rsp data",
                        {bus2.rsp_zr, bus2.rsp_zi, bus2.rsp_size, bus2.rsp_overflow, bus2.rsp_timeout},
                        {10'd0, 10'd0, 1'b0, 1'b1, 1'b1});
            stubHang = 1'b0;
            nextCycle();
            #3;
            checkOutput("wd timeout held", bus2.rsp_timeout, 1'b1);
            after = '{2'b01, 10'd5, 10'd6, 1'b0, 1'b0, 2'b01, {10'd5, 10'd3, 10'd0, 10'd0}, 2'b01};
            applyStimulus(after, "wd recovery");
            bus2.req_valid = 2'b00;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
